// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, FSM states
// and default geometry.
package dm_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int unsigned DM_AW = 10;
  localparam int unsigned DM_DW = 32;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin grant: a lone requester wins; on conflict the port
// that did not win last time is granted. Output is one-hot (or zero).
module dm_rr_pick
  import dm_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // Pick the winner from the requests and the previous winner
  always_comb begin
    gnt = '0;
    if (req0 && req1) begin
      if (last_gnt == PORT_LD) gnt[PORT_CPU] = 1'b1;
      else                     gnt[PORT_LD]  = 1'b1;
    end else begin
      gnt[PORT_CPU] = req0;
      gnt[PORT_LD]  = req1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU load/store (port 0) and loader/debug (port 1)
// share a single-port memory; one access per clock, 1-cycle read latency.
// Optional port-1 bus locking is compiled in with DM_ARB_LOCK_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW       = DM_AW,
  parameter int unsigned DW       = DM_DW,
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [31:0]   addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [31:0]   addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  input  logic          lock1,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err
);

  logic       last_gnt;
  logic [1:0] rr_gnt;
  logic       locked_now;

  dm_rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .gnt      (rr_gnt)
  );

`ifdef DM_ARB_LOCK_EN
  state_t      state, state_next;
  logic [3:0]  lock_cnt, lock_cnt_next;

  // Port 1 keeps the bus only while it is still requesting with lock1 set;
  // otherwise this cycle already arbitrates normally (port 0 wins a conflict
  // because last_gnt is port 1 after any locked grant).
  assign locked_now = (state == ST_LOCKED) && req1 && lock1;

  // Lock state and consecutive-grant counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_ARB;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // The entry grant (made in ARB) is the first of the run, so the run ends
  // on the locked grant with lock_cnt == LOCK_MAX-2.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    unique case (state)
      ST_ARB: begin
        if (gnt1 && lock1) begin
          state_next    = ST_LOCKED;
          lock_cnt_next = '0;
        end
      end
      ST_LOCKED: begin
        if (!locked_now) begin
          state_next = ST_ARB;
        end else if (lock_cnt == 4'(LOCK_MAX - 2)) begin
          state_next = ST_ARB;
        end else begin
          lock_cnt_next = lock_cnt + 4'd1;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end
`else
  localparam int unsigned LOCK_MAX_UNUSED = LOCK_MAX;
  logic lock1_unused;
  assign lock1_unused = lock1;
  assign locked_now   = 1'b0;
`endif

  // Grant selection, forced off while in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (locked_now) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = rr_gnt[PORT_CPU];
        gnt1 = rr_gnt[PORT_LD];
      end
    end
  end

  // Memory drive follows the granted port; idle bus is all zero
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Round-robin history, read-data return and address-error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= PORT_LD;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      addr_err <= 1'b0;
    end else begin
      if (gnt0)      last_gnt <= PORT_CPU;
      else if (gnt1) last_gnt <= PORT_LD;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
      addr_err <= (gnt0 || gnt1) &&
                  ((mem_addr[31:AW+2] != '0) || (mem_addr[1:0] != 2'b00));
    end
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter sharing the single-port 1K x 32 data memory between the CPU load/store path (port 0) and the memory-loader/debug port (port 1).
- Picks at most one access per clock, drives the memory's address, write data and write enable, and returns registered read data with fixed 1-cycle latency.
- Sits between the datapath/loader and the data memory. The memory is written on posedge and read combinationally.

Parameters:
- AW, 10, word-index width; the memory is indexed by addr[AW+1:2].
- DW, 32, data width.
- LOCK_MAX, 15, maximum consecutive locked grants before a forced release (used only with the optional feature).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 (CPU) access request.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  32  port 0 byte address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 granted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (registered).
- rdata0  out  DW  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (loader).
- lock1  in  1  port 1 requests back-to-back ownership (ignored unless the feature is compiled in).
- mem_we  out  1  memory write enable.
- mem_addr  out  32  byte address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_rdata  in  DW  combinational memory read data.
- addr_err  out  1  pulse: the granted address has addr[31:AW+2] != 0 or addr[1:0] != 0.

Behaviour:
- Reset (synchronous): last_gnt=1 so port 0 wins the first conflict; state=ARB. rvalid0/1=0, rdata0/1=0, addr_err=0. Combinational outputs are forced low while reset=1, so mem_we=0 and gnt0/gnt1=0 during reset.
- Grant (combinational each cycle):
  - only one req → grant it;
  - both req → grant the port != last_gnt (round-robin);
  - neither → no grant.
  - last_gnt updates at posedge to the granted port; it holds when idle.
- Memory drive:
  - mem_addr/mem_wdata follow the granted port.
  - mem_we = gnt & we of that port.
  - With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- Read latency: a granted read in cycle N gives rvalidX=1 and rdataX=mem_rdata captured at posedge N, both visible in cycle N+1. rvalid is a single-cycle pulse. rdataX holds its last value otherwise.
- Writes produce no rvalid. The memory commits the write at posedge N.
- Requester rule: a requester holds req/we/addr/wdata stable until it sees gnt. An ungranted request is not queued internally.
- Back-to-back:
  - a port may be granted in consecutive cycles only when the other port is not requesting;
  - under continuous dual requests, grants alternate 0,1,0,1.
- Read-after-write across ports in adjacent cycles returns the new data, because the write commits before the next read.
- Address error:
  - an out-of-range or misaligned granted access still proceeds, using the index bits only;
  - addr_err is registered and pulses for 1 cycle in N+1.
- Reset mid-operation: a pending rvalid is cancelled (rvalid=0 in the cycle after reset). A write granted in the reset cycle is suppressed (mem_we=0).
- States: ARB (normal round-robin) and LOCKED (feature only).

Optional Feature:
- Macro: DM_ARB_LOCK_EN.
- With the macro:
  - A grant to port 1 with lock1=1 moves ARB→LOCKED.
  - In LOCKED, port 1 has absolute priority; port 0 is stalled (gnt0=0).
  - LOCKED→ARB when lock1=0, when req1=0, or after LOCK_MAX consecutive locked grants. On that release, last_gnt=1, so port 0 wins the next conflict.
  - A 4-bit lock counter is cleared on entry to LOCKED and on reset.
- Without the macro: lock1 is ignored, the LOCKED state and counter do not exist, and behaviour is pure round-robin.

Decomposition:
- Shared package dm_arb_pkg:
  - port-index constants PORT_CPU=0 and PORT_LD=1;
  - state encoding ST_ARB / ST_LOCKED;
  - default AW/DW constants.
- One natural sub-module, dm_rr_pick: the 2-way round-robin grant logic, taking req0, req1 and last_gnt and returning one-hot gnt.
- Everything else stays in dm_arbiter.

Test Plan:
- Reset then idle → gnt0=gnt1=0, mem_we=0, rvalid0=rvalid1=0 for 5 cycles.
- Port 1 writes 0xDEADBEEF to addr 0x10; next cycle port 0 reads 0x10 → gnt1 in cycle 1; in cycle 3 rvalid0=1 and rdata0=0xDEADBEEF.
- req0 and req1 both held for 6 cycles, reading addrs 0x0 and 0x4 → grants 0,1,0,1,0,1; each port gets rvalid exactly on the cycle after its grant.
- Port 0 reads addr 0x00001002 → access to word 0; addr_err=1 for exactly 1 cycle.
- Reset asserted in the cycle after a granted read → rvalid=0 in the following cycle, and last_gnt returns to 1.
- With DM_ARB_LOCK_EN, lock1=1 and both ports requesting continuously → 15 consecutive gnt1, then gnt0; without the macro, grants alternate.
